// File: rtl/datapath_arbiter.sv
// rtl/datapath_arbiter.sv - round-robin arbiter sharing one ALU datapath among NREQ requesters
module datapath_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [4*NREQ-1:0]   req_opcode,
    input  logic [8*NREQ-1:0]   req_a,
    input  logic [8*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]     ack,
    output logic [WIDTH-1:0]    rsp_result,
    output logic                rsp_invalid,
    output logic                rsp_timeout,
    output logic [IDW-1:0]      grant_id,
    output logic                busy,
    output logic                dp_enable,
    output logic [3:0]          dp_opcode,
    output logic [7:0]          dp_a,
    output logic [7:0]          dp_b,
    input  logic                dp_done,
    input  logic [WIDTH-1:0]    dp_result
);

    localparam int              CNTW      = $clog2(TIMEOUT);
    localparam logic [CNTW-1:0] CNT_LAST  = CNTW'(TIMEOUT - 1);
    localparam logic [IDW-1:0]  LAST_INIT = IDW'(NREQ - 1);
    localparam logic [NREQ-1:0] ONE_HOT0  = NREQ'(1);
    localparam logic [3:0]      OP_MAX    = 4'b0011;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t          state;
    logic [IDW-1:0]  last_grant;
    logic [CNTW-1:0] cnt;

    logic [IDW-1:0]  winner;
    logic [IDW-1:0]  idx;
    logic [3:0]      win_opcode;
    logic [7:0]      win_a;
    logic [7:0]      win_b;

    // Round-robin search: walk offsets from farthest to nearest so the nearest
    // requester after last_grant is the final (winning) assignment.
    always_comb begin
        winner = last_grant;
        idx    = '0;
        for (int i = NREQ; i >= 1; i--) begin
            idx = IDW'((int'(last_grant) + i) % NREQ);
            if (req[idx]) begin
                winner = idx;
            end
        end
        win_opcode = req_opcode[winner*4 +: 4];
        win_a      = req_a[winner*8 +: 8];
        win_b      = req_b[winner*8 +: 8];
    end

    // Arbitration FSM with all outputs registered; response fields default to
    // zero every cycle so they are only nonzero during the single DONE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_grant  <= LAST_INIT;
            cnt         <= '0;
            ack         <= '0;
            rsp_result  <= '0;
            rsp_invalid <= 1'b0;
            rsp_timeout <= 1'b0;
            grant_id    <= '0;
            busy        <= 1'b0;
            dp_enable   <= 1'b0;
            dp_opcode   <= '0;
            dp_a        <= '0;
            dp_b        <= '0;
        end else begin
            ack         <= '0;
            rsp_result  <= '0;
            rsp_invalid <= 1'b0;
            rsp_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (req != '0) begin
                        grant_id  <= winner;
                        dp_opcode <= win_opcode;
                        dp_a      <= win_a;
                        dp_b      <= win_b;
                        busy      <= 1'b1;
                        if (win_opcode <= OP_MAX) begin
                            state     <= BUSY;
                            cnt       <= '0;
                            dp_enable <= 1'b1;
                        end else begin
                            // Invalid opcodes never reach the datapath.
                            state       <= DONE;
                            ack         <= ONE_HOT0 << winner;
                            rsp_invalid <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (dp_done) begin
                        state      <= DONE;
                        dp_enable  <= 1'b0;
                        ack        <= ONE_HOT0 << grant_id;
                        rsp_result <= dp_result;
                    end else if (cnt == CNT_LAST) begin
                        state       <= DONE;
                        dp_enable   <= 1'b0;
                        ack         <= ONE_HOT0 << grant_id;
                        rsp_timeout <= 1'b1;
                    end
                end
                DONE: begin
                    last_grant <= grant_id;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    dp_enable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_datapath_arbiter.sv
// tb/tb_datapath_arbiter.sv - scoreboard bench for datapath_arbiter
module tb_datapath_arbiter;

    localparam int NREQ    = 4;
    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 64;
    localparam int IDW     = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic [NREQ-1:0]     req;
    logic [4*NREQ-1:0]   req_opcode;
    logic [8*NREQ-1:0]   req_a;
    logic [8*NREQ-1:0]   req_b;
    logic [NREQ-1:0]     ack;
    logic [WIDTH-1:0]    rsp_result;
    logic                rsp_invalid;
    logic                rsp_timeout;
    logic [IDW-1:0]      grant_id;
    logic                busy;
    logic                dp_enable;
    logic [3:0]          dp_opcode;
    logic [7:0]          dp_a;
    logic [7:0]          dp_b;
    logic                dp_done;
    logic [WIDTH-1:0]    dp_result;

    datapath_arbiter #(
        .NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .IDW(IDW)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_opcode(req_opcode),
        .req_a(req_a), .req_b(req_b), .ack(ack), .rsp_result(rsp_result),
        .rsp_invalid(rsp_invalid), .rsp_timeout(rsp_timeout),
        .grant_id(grant_id), .busy(busy), .dp_enable(dp_enable),
        .dp_opcode(dp_opcode), .dp_a(dp_a), .dp_b(dp_b),
        .dp_done(dp_done), .dp_result(dp_result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0]  ack;
        logic [WIDTH-1:0] res;
        logic             inv;
        logic             to;
    } exp_t;

    exp_t exp_q[$];
    int   dly_q[$];

    int tests = 0;
    int fails = 0;

    // Reference model state: last granted requester and per-requester stimulus.
    int         lg = NREQ - 1;
    logic [3:0] op_v[NREQ];
    logic [7:0] a_v[NREQ];
    logic [7:0] b_v[NREQ];
    int         d_v[NREQ];
    logic       abort = 1'b0;

    task automatic check(input string name, input logic ok, input string detail);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    function automatic logic [15:0] alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'd0:    return {8'h00, a ^ b};
            4'd1:    return {8'h00, a} + {8'h00, b};
            4'd2:    return {8'h00, a} - {8'h00, b};
            default: return {8'h00, a} * {8'h00, b};
        endcase
    endfunction

    task automatic drive_ops();
        for (int i = 0; i < NREQ; i++) begin
            req_opcode[4*i +: 4] = op_v[i];
            req_a[8*i +: 8]      = a_v[i];
            req_b[8*i +: 8]      = b_v[i];
        end
    endtask

    // Present a set of simultaneous requests, predict grant order and responses,
    // then act as the requesters until every one has been acknowledged.
    task automatic run_round(input logic [NREQ-1:0] mask);
        logic [NREQ-1:0] pending;
        int   id;
        int   budget;
        int   first_ack;
        int   single_id;
        exp_t e;
        drive_ops();
        pending   = mask;
        single_id = -1;
        if ($countones(mask) == 1) begin
            for (int i = 0; i < NREQ; i++) if (mask[i]) single_id = i;
        end
        while (pending != '0) begin
            id = lg;
            for (int s = 1; s <= NREQ; s++) begin
                id = (lg + s) % NREQ;
                if (pending[id]) break;
            end
            e.ack     = '0;
            e.ack[id] = 1'b1;
            if (op_v[id] > 4'd3) begin
                e.res = '0; e.inv = 1'b1; e.to = 1'b0;
            end else begin
                e.inv = 1'b0;
                e.to  = (d_v[id] == 0);
                e.res = e.to ? 16'h0000 : alu(op_v[id], a_v[id], b_v[id]);
                dly_q.push_back(d_v[id]);
            end
            exp_q.push_back(e);
            pending[id] = 1'b0;
            lg = id;
        end
        req       = mask;
        budget    = 0;
        first_ack = 0;
        do begin
            @(negedge clk);
            budget++;
            if (ack != '0 && first_ack == 0) first_ack = budget;
            for (int i = 0; i < NREQ; i++) if (ack[i]) req[i] = 1'b0;
            if (dp_enable) begin
                req_opcode[grant_id*4 +: 4] = 4'($urandom);
                req_a[grant_id*8 +: 8]      = 8'($urandom);
                req_b[grant_id*8 +: 8]      = 8'($urandom);
            end
        end while ((req != '0 || busy) && budget < 3000);
        check("round_complete", budget < 3000, $sformatf("got budget=%0d, required < 3000", budget));
        if (single_id >= 0) begin
            int lat;
            if (op_v[single_id] > 4'd3) lat = 1;
            else lat = ((d_v[single_id] == 0) ? TIMEOUT : d_v[single_id]) + 1;
            check("ack_latency", first_ack == lat, $sformatf("got %0d cycles, required %0d", first_ack, lat));
        end
    endtask

    // Datapath model: completes after the scheduled number of BUSY cycles
    // (0 = never), checks operand stability and enable duration.
    initial begin
        int         cyc;
        int         cur;
        int         want;
        logic [3:0] o0;
        logic [7:0] a0;
        logic [7:0] b0;
        cyc = 0; cur = 0; o0 = '0; a0 = '0; b0 = '0;
        dp_done = 1'b0; dp_result = '0;
        forever begin
            @(negedge clk);
            if (dp_enable) begin
                cyc++;
                if (cyc == 1) begin
                    check("enable_expected", dly_q.size() != 0, $sformatf("got dp_enable with %0d scheduled ops, required >0", dly_q.size()));
                    cur = (dly_q.size() != 0) ? dly_q.pop_front() : 0;
                    o0 = dp_opcode; a0 = dp_a; b0 = dp_b;
                end else begin
                    check("operand_stable", {dp_opcode, dp_a, dp_b} == {o0, a0, b0},
                          $sformatf("got op=%h a=%h b=%h, required op=%h a=%h b=%h", dp_opcode, dp_a, dp_b, o0, a0, b0));
                end
                dp_done   = (cur != 0 && cyc == cur);
                dp_result = dp_done ? alu(dp_opcode, dp_a, dp_b) : 16'($urandom);
            end else begin
                if (cyc != 0 && !abort) begin
                    want = (cur == 0) ? TIMEOUT : cur;
                    check("enable_length", cyc == want, $sformatf("got %0d cycles, required %0d", cyc, want));
                end
                cyc       = 0;
                dp_done   = ($urandom_range(0, 3) == 0);
                dp_result = 16'($urandom);
            end
        end
    end

    // Monitor: every ack pops one expected response; outside ack the
    // response fields must read zero.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ack != '0) begin
                check("ack_expected", exp_q.size() != 0, $sformatf("got ack=%b with empty scoreboard, required none", ack));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("response", ack == e.ack && rsp_result == e.res && rsp_invalid == e.inv && rsp_timeout == e.to && busy,
                          $sformatf("got ack=%b res=%h inv=%b to=%b busy=%b, required ack=%b res=%h inv=%b to=%b busy=1",
                                    ack, rsp_result, rsp_invalid, rsp_timeout, busy, e.ack, e.res, e.inv, e.to));
                end
            end else begin
                check("rsp_idle_zero", rsp_result == '0 && !rsp_invalid && !rsp_timeout,
                      $sformatf("got res=%h inv=%b to=%b, required all 0", rsp_result, rsp_invalid, rsp_timeout));
            end
        end
    end

    initial begin
        int n;
        reset = 1'b1; req = '0; req_opcode = '0; req_a = '0; req_b = '0;
        for (int i = 0; i < NREQ; i++) begin op_v[i] = '0; a_v[i] = '0; b_v[i] = '0; d_v[i] = 1; end
        repeat (3) @(negedge clk);
        check("reset_state", ack == '0 && !busy && !dp_enable && dp_opcode == '0 && dp_a == '0 && dp_b == '0 && grant_id == '0,
              $sformatf("got ack=%b busy=%b en=%b op=%h a=%h b=%h gid=%0d, required all 0",
                        ack, busy, dp_enable, dp_opcode, dp_a, dp_b, grant_id));
        reset = 1'b0;
        @(negedge clk);

        // Single request, done in BUSY cycle 2.
        op_v[0] = 4'd1; a_v[0] = 8'h05; b_v[0] = 8'h03; d_v[0] = 2;
        run_round(4'b0001);

        // Round robin with all four requesting, two rounds.
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                op_v[i] = 4'($urandom_range(0, 3)); a_v[i] = 8'($urandom); b_v[i] = 8'($urandom); d_v[i] = 1;
            end
            run_round(4'b1111);
        end

        // Invalid opcode from requester 2.
        op_v[2] = 4'b0101; a_v[2] = 8'h11; b_v[2] = 8'h22;
        run_round(4'b0100);

        // Timeout, then done on the final allowed cycle.
        op_v[3] = 4'd3; a_v[3] = 8'h0c; b_v[3] = 8'h0d; d_v[3] = 0;
        run_round(4'b1000);
        d_v[3] = TIMEOUT;
        run_round(4'b1000);

        // Reset during BUSY cycle 3 of requester 1.
        op_v[1] = 4'd2; a_v[1] = 8'h40; b_v[1] = 8'h01;
        drive_ops();
        dly_q.push_back(0);
        req = 4'b0010;
        n = 0;
        for (int c = 0; c < 20 && n < 3; c++) begin
            @(negedge clk);
            if (dp_enable) n++;
        end
        check("reach_busy3", n == 3, $sformatf("got %0d BUSY cycles, required 3", n));
        reset = 1'b1; abort = 1'b1; req = '0;
        @(negedge clk);
        check("reset_abort", !dp_enable && !busy && ack == '0,
              $sformatf("got en=%b busy=%b ack=%b, required 0 0 0000", dp_enable, busy, ack));
        reset = 1'b0; lg = NREQ - 1;
        @(negedge clk);
        @(negedge clk);
        abort = 1'b0;
        for (int i = 0; i < 2; i++) begin
            op_v[i] = 4'($urandom_range(0, 3)); a_v[i] = 8'($urandom); b_v[i] = 8'($urandom); d_v[i] = 3;
        end
        run_round(4'b0011);

        // Randomized rounds.
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                op_v[i] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
                a_v[i]  = 8'($urandom);
                b_v[i]  = 8'($urandom);
                case ($urandom_range(0, 15))
                    0:       d_v[i] = 0;
                    1:       d_v[i] = TIMEOUT;
                    default: d_v[i] = $urandom_range(1, 6);
                endcase
            end
            run_round(4'($urandom_range(1, 15)));
        end

        repeat (4) @(negedge clk);
        check("scoreboard_drained", exp_q.size() == 0, $sformatf("got %0d outstanding, required 0", exp_q.size()));
        check("datapath_drained", dly_q.size() == 0, $sformatf("got %0d outstanding, required 0", dly_q.size()));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
